// File: rtl/isolator_blip_detect_ctrl.sv
// Blip detector for an isolator output line. Synchronises the raw
// isolator signal, measures each high pulse in clk cycles, and reports pulses
// shorter than MIN_PULSE to the host through a valid/ack handshake. It also
// keeps a saturating blip tally and a sticky overflow flag.
module isolator_blip_detect_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  MIN_PULSE   = 8'd16,
  parameter logic [7:0]  HOLDOFF     = 8'd32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iso_in,
  input  logic       enable,
  input  logic       blip_ack,
  output logic       blip_valid,
  output logic [7:0] blip_width,
  output logic [7:0] blip_total,
  output logic       overflow,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StMeasure, StHoldoff} state_e;

  state_e                 state_q;
  logic [7:0]             cnt_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   iso_d_q;
  logic                   iso_s;
  logic                   rise;

  assign iso_s = sync_q[SYNC_STAGES-1];
  assign rise  = iso_s & ~iso_d_q;

  // Synchroniser chain plus one extra delay stage for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      iso_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], iso_in};
      iso_d_q <= iso_s;
    end
  end

  // Detection FSM with width counter and registered host-facing outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      blip_valid <= 1'b0;
      blip_width <= 8'd0;
      blip_total <= 8'd0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Ack clears a pending report; a blip captured on the same edge
      // overrides this below because the later assignment wins.
      if (blip_valid && blip_ack) begin
        blip_valid <= 1'b0;
      end

      if (!enable) begin
        state_q <= StIdle;
        cnt_q   <= 8'd0;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (rise) begin
              state_q <= StMeasure;
              cnt_q   <= 8'd1;
              busy    <= 1'b1;
            end
          end
          StMeasure: begin
            if (iso_s) begin
              if (cnt_q != 8'hff) begin
                cnt_q <= cnt_q + 8'd1;
              end
            end else begin
              if (cnt_q < MIN_PULSE) begin
                if (!blip_valid || blip_ack) begin
                  blip_valid <= 1'b1;
                  blip_width <= cnt_q;
                end else begin
                  overflow <= 1'b1;
                end
                if (blip_total != 8'hff) begin
                  blip_total <= blip_total + 8'd1;
                end
              end
              state_q <= StHoldoff;
              cnt_q   <= 8'd0;
            end
          end
          StHoldoff: begin
            if (cnt_q == HOLDOFF - 8'd1) begin
              state_q <= StIdle;
              cnt_q   <= 8'd0;
              busy    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_isolator_blip_detect_ctrl.sv
// Testbench for isolator_blip_detect_ctrl: directed handshake/overflow/reset
// scenarios followed by randomized pulse trains checked through a scoreboard.
module tb_isolator_blip_detect_ctrl;

  localparam int MinPulse = 16;
  localparam int Holdoff  = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iso_in = 1'b0;
  logic       enable = 1'b1;
  logic       ack_dir = 1'b0;
  logic       ack_mon = 1'b0;
  logic       blip_ack;
  logic       blip_valid;
  logic [7:0] blip_width;
  logic [7:0] blip_total;
  logic       overflow;
  logic       busy;

  assign blip_ack = ack_dir | ack_mon;

  isolator_blip_detect_ctrl #(
    .SYNC_STAGES(2),
    .MIN_PULSE  (8'd16),
    .HOLDOFF    (8'd32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .iso_in    (iso_in),
    .enable    (enable),
    .blip_ack  (blip_ack),
    .blip_valid(blip_valid),
    .blip_width(blip_width),
    .blip_total(blip_total),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #15 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Drive a w-cycle high pulse followed by g low cycles, counting busy samples.
  task automatic run_pulse(input int w, input int g, output int busy_n);
    busy_n = 0;
    iso_in = 1'b1;
    repeat (w) begin
      step();
      busy_n += int'(busy);
    end
    iso_in = 1'b0;
    repeat (g) begin
      step();
      busy_n += int'(busy);
    end
  endtask

  task automatic host_ack();
    ack_dir = 1'b1;
    step();
    ack_dir = 1'b0;
  endtask

  // Scoreboard monitor: every report the DUT presents is matched against the
  // oldest expected width, then acknowledged for one cycle.
  initial begin
    int w;
    forever begin
      @(negedge clk);
      if (mon_en && blip_valid && !ack_mon) begin
        if (exp_q.size() == 0) begin
          check("unexpected_blip", 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          check("sb_blip_width", 32'(blip_width), 32'(w));
        end
        check("sb_no_overflow", 32'(overflow), 32'd0);
        ack_mon = 1'b1;
      end else begin
        ack_mon = 1'b0;
      end
    end
  end

  // Reference model: a pulse starting at cycle s is measured only if the
  // detector has re-armed by then; it re-arms HOLDOFF+1 cycles after the
  // pulse ends. Measured width saturates at 255.
  int ready;
  int n_blips;

  task automatic model_pulse(input int w, input int g);
    int bn;
    int mw;
    if (cyc >= ready) begin
      ready = cyc + w + Holdoff + 1;
      mw = (w > 255) ? 255 : w;
      if (mw < MinPulse) begin
        exp_q.push_back(mw);
        n_blips++;
      end
    end
    run_pulse(w, g, bn);
  endtask

  initial begin
    int bn;
    int w;
    int g;
    int r;

    // Reset state
    repeat (3) step();
    check("rst_valid", 32'(blip_valid), 32'd0);
    check("rst_width", 32'(blip_width), 32'd0);
    check("rst_total", 32'(blip_total), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (3) step();

    // 5-cycle blip, busy for 5 measure + 32 holdoff cycles
    run_pulse(5, 50, bn);
    check("t1_valid", 32'(blip_valid), 32'd1);
    check("t1_width", 32'(blip_width), 32'd5);
    check("t1_total", 32'(blip_total), 32'd1);
    check("t1_overflow", 32'(overflow), 32'd0);
    check("t1_busy_cycles", 32'(bn), 32'd37);
    host_ack();
    check("t1_ack_clears", 32'(blip_valid), 32'd0);
    repeat (5) step();

    // 20-cycle legitimate pulse
    run_pulse(20, 50, bn);
    check("t2_valid", 32'(blip_valid), 32'd0);
    check("t2_total", 32'(blip_total), 32'd1);
    check("t2_busy_cycles", 32'(bn), 32'd52);
    check("t2_idle", 32'(busy), 32'd0);

    // Disarmed: pulse ignored, no busy
    enable = 1'b0;
    run_pulse(5, 50, bn);
    check("en0_valid", 32'(blip_valid), 32'd0);
    check("en0_total", 32'(blip_total), 32'd1);
    check("en0_busy_cycles", 32'(bn), 32'd0);
    enable = 1'b1;
    repeat (5) step();

    // Pending 3-blip, then 7-blip captured on the same edge as ack
    run_pulse(3, 40, bn);
    check("t4_first_width", 32'(blip_width), 32'd3);
    iso_in = 1'b1;
    repeat (7) step();
    iso_in = 1'b0;
    repeat (2) step();
    ack_dir = 1'b1;  // sampled on the capture edge (SYNC_STAGES+1 after fall)
    step();
    ack_dir = 1'b0;
    check("t4_valid", 32'(blip_valid), 32'd1);
    check("t4_width", 32'(blip_width), 32'd7);
    check("t4_overflow", 32'(overflow), 32'd0);
    check("t4_total", 32'(blip_total), 32'd3);
    host_ack();
    check("t4_ack_clears", 32'(blip_valid), 32'd0);
    repeat (40) step();

    // Two 4-cycle blips 50 cycles apart, no ack in between
    run_pulse(4, 46, bn);
    run_pulse(4, 46, bn);
    check("t3_valid", 32'(blip_valid), 32'd1);
    check("t3_width_kept", 32'(blip_width), 32'd4);
    check("t3_total", 32'(blip_total), 32'd5);
    check("t3_overflow", 32'(overflow), 32'd1);
    host_ack();
    check("t3_ack_clears", 32'(blip_valid), 32'd0);
    check("t3_overflow_sticky", 32'(overflow), 32'd1);

    // Pulse during holdoff ignored; same pulse after holdoff counted
    run_pulse(20, 10, bn);
    run_pulse(3, 40, bn);
    check("ho_ignored_valid", 32'(blip_valid), 32'd0);
    check("ho_ignored_total", 32'(blip_total), 32'd5);
    run_pulse(3, 40, bn);
    check("ho_counted_valid", 32'(blip_valid), 32'd1);
    check("ho_counted_width", 32'(blip_width), 32'd3);
    check("ho_counted_total", 32'(blip_total), 32'd6);
    host_ack();
    repeat (5) step();

    // Reset two cycles into the measurement of a 6-cycle pulse
    iso_in = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    #1;
    check("rm_valid", 32'(blip_valid), 32'd0);
    check("rm_width", 32'(blip_width), 32'd0);
    check("rm_total", 32'(blip_total), 32'd0);
    check("rm_overflow", 32'(overflow), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    repeat (2) step();
    iso_in = 1'b0;
    repeat (5) step();
    reset = 1'b0;
    repeat (50) step();
    check("rm_after_valid", 32'(blip_valid), 32'd0);
    check("rm_after_total", 32'(blip_total), 32'd0);

    // Randomized pulse train against the model, scoreboard handles acks
    mon_en = 1'b1;
    ready = cyc;
    n_blips = 0;
    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70) w = int'($urandom_range(1, 15));
      else if (r < 95) w = int'($urandom_range(16, 60));
      else w = int'($urandom_range(250, 300));
      g = int'($urandom_range(1, 90));
      model_pulse(w, g);
    end
    repeat (60) step();
    check("rnd_queue_drained", 32'(exp_q.size()), 32'd0);
    check("rnd_total", 32'(blip_total), 32'((n_blips > 255) ? 255 : n_blips));
    check("rnd_overflow", 32'(overflow), 32'd0);

    // 300 blips spaced 60 cycles apart: tally saturates
    for (int i = 0; i < 300; i++) begin
      w = int'($urandom_range(1, 15));
      model_pulse(w, 60 - w);
    end
    repeat (60) step();
    check("sat_queue_drained", 32'(exp_q.size()), 32'd0);
    check("sat_total", 32'(blip_total), 32'((n_blips > 255) ? 255 : n_blips));
    check("sat_total_255", 32'(blip_total), 32'd255);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
